// File: rtl/draw_pkg.sv
// Shared definitions for the VGA draw path.
// Plotter FSM states and default framebuffer geometry.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    WAIT,
    PLOT,
    DONE
  } plot_state_t;

  localparam int DRAW_WIDTH_DEF  = 640;
  localparam int DRAW_HEIGHT_DEF = 480;

endpackage

// File: rtl/particle_plotter_if.sv
// Particle store read port and framebuffer write port
// of the particle plotter.
interface particle_plotter_if #(
  parameter int DRAW_ADDRW = 19,
  parameter int PART_ADDRW = 6
);

  logic [PART_ADDRW-1:0] part_addr;
  logic [9:0]            part_x;
  logic [9:0]            part_y;
  logic [DRAW_ADDRW-1:0] draw_addr_write;
  logic                  draw_data_in;
  logic                  draw_we;

  modport master (
    output part_addr,
    input  part_x,
    input  part_y,
    output draw_addr_write,
    output draw_data_in,
    output draw_we
  );

  modport slave (
    input  part_addr,
    output part_x,
    output part_y,
    input  draw_addr_write,
    input  draw_data_in,
    input  draw_we
  );

endinterface

// File: rtl/particle_plotter.sv
// Frame renderer: clears the 1-bit framebuffer, then plots
// every particle as a DOT_SIZE x DOT_SIZE white square.
module particle_plotter
  import draw_pkg::*;
#(
  parameter int DRAW_WIDTH  = DRAW_WIDTH_DEF,
  parameter int DRAW_HEIGHT = DRAW_HEIGHT_DEF,
  parameter int DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
  parameter int DRAW_ADDRW  = $clog2(DRAW_SIZE),
  parameter int N_PART      = 64,
  parameter int PART_ADDRW  = (N_PART > 1) ? $clog2(N_PART) : 1,
  parameter int DOT_SIZE    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  particle_plotter_if.master bus,
  output logic               busy,
  output logic               done
);

  localparam int DOTW = (DOT_SIZE > 1) ? $clog2(DOT_SIZE) : 1;

  localparam logic [10:0] W11 = 11'(DRAW_WIDTH);
  localparam logic [10:0] H11 = 11'(DRAW_HEIGHT);

  localparam logic [DRAW_ADDRW-1:0] LAST_ADDR =
    DRAW_ADDRW'(DRAW_SIZE - 1);
  localparam logic [DRAW_ADDRW-1:0] ROW_STEP =
    DRAW_ADDRW'(DRAW_WIDTH);
  localparam logic [PART_ADDRW-1:0] LAST_PART =
    PART_ADDRW'(N_PART - 1);
  localparam logic [DOTW-1:0] LAST_D = DOTW'(DOT_SIZE - 1);

  plot_state_t state, state_n;

  logic [DRAW_ADDRW-1:0] clr_q, clr_n;
  logic [PART_ADDRW-1:0] p_q, p_n;
  logic [9:0]            x0_q, x0_n;
  logic [9:0]            y0_q, y0_n;
  logic [DOTW-1:0]       dx_q, dx_n;
  logic [DOTW-1:0]       dy_q, dy_n;
  logic [DRAW_ADDRW-1:0] rb_q, rb_n;

  logic [DRAW_ADDRW-1:0] addr_q, addr_n;
  logic                  data_q, data_n;
  logic                  we_q, we_n;
  logic                  busy_n, done_n;

  logic                  pix;
  logic [10:0]           px, py;

  // Every output register is loaded with what the next state drives.
  always_comb begin
    state_n = state;
    clr_n   = clr_q;
    p_n     = p_q;
    x0_n    = x0_q;
    y0_n    = y0_q;
    dx_n    = dx_q;
    dy_n    = dy_q;
    rb_n    = rb_q;
    we_n    = 1'b0;
    data_n  = 1'b0;
    addr_n  = '0;
    pix     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          clr_n   = '0;
          we_n    = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_q == LAST_ADDR) begin
          state_n = FETCH;
          p_n     = '0;
        end else begin
          clr_n  = clr_q + 1'b1;
          addr_n = clr_q + 1'b1;
          we_n   = 1'b1;
        end
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        state_n = PLOT;
        x0_n    = bus.part_x;
        y0_n    = bus.part_y;
        dx_n    = '0;
        dy_n    = '0;
        rb_n    = DRAW_ADDRW'(32'(bus.part_y) * 32'(DRAW_WIDTH));
        pix     = 1'b1;
      end
      PLOT: begin
        if (dx_q == LAST_D && dy_q == LAST_D) begin
          if (p_q == LAST_PART) begin
            state_n = DONE;
          end else begin
            state_n = FETCH;
            p_n     = p_q + 1'b1;
          end
        end else begin
          pix = 1'b1;
          if (dx_q == LAST_D) begin
            dx_n = '0;
            dy_n = dy_q + 1'b1;
            rb_n = rb_q + ROW_STEP;
          end else begin
            dx_n = dx_q + 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // 11-bit sums so an edge particle clips instead of wrapping.
    px = {1'b0, x0_n} + 11'(dx_n);
    py = {1'b0, y0_n} + 11'(dy_n);
    if (pix && px < W11 && py < H11) begin
      we_n   = 1'b1;
      data_n = 1'b1;
      addr_n = rb_n + DRAW_ADDRW'(px);
    end

    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      clr_q  <= '0;
      p_q    <= '0;
      x0_q   <= '0;
      y0_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      rb_q   <= '0;
      addr_q <= '0;
      data_q <= 1'b0;
      we_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      clr_q  <= clr_n;
      p_q    <= p_n;
      x0_q   <= x0_n;
      y0_q   <= y0_n;
      dx_q   <= dx_n;
      dy_q   <= dy_n;
      rb_q   <= rb_n;
      addr_q <= addr_n;
      data_q <= data_n;
      we_q   <= we_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  assign bus.part_addr       = p_q;
  assign bus.draw_addr_write = addr_q;
  assign bus.draw_data_in    = data_q;
  assign bus.draw_we         = we_q;

endmodule
